// File: rtl/pci_pkg.sv
// Shared definitions for the PCI initiator: bus commands, FSM encoding and
// default timing constants.
package pci_pkg;

    localparam logic [3:0] CMD_READ  = 4'b0001;
    localparam logic [3:0] CMD_WRITE = 4'b0010;

    localparam int DEFAULT_DEVSEL_TIMEOUT = 5;

    localparam logic [15:0] DEVICE_ADDRESS = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_TURN,
        ST_DATA,
        ST_RELEASE
    } state_t;

endpackage

// File: rtl/pci_ad_io.sv
// Tri-state driver for the multiplexed AD bus with a registered sample of the
// bus value, taken whenever a read data phase completes.
module pci_ad_io (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_oe,
    input  logic [31:0] i_out,
    input  logic        i_capture,
    output logic [31:0] o_sample,
    inout  wire  [31:0] io_ad
);

    logic [31:0] r_sample;

    assign io_ad    = i_oe ? i_out : 32'bz;
    assign o_sample = r_sample;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sample <= '0;
        end else if (i_capture) begin
            r_sample <= io_ad;
        end
    end

endmodule

// File: rtl/pci_initiator.sv
// PCI bus master: turns a local request into an address phase plus N data
// phases, returns read data / write acks and flags master abort.
module pci_initiator
    import pci_pkg::*;
#(
    parameter int LEN_W          = 4,
    parameter int DEVSEL_TIMEOUT = DEFAULT_DEVSEL_TIMEOUT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req,
    input  logic [31:0]      i_req_addr,
    input  logic [3:0]       i_req_cmd,
    input  logic [3:0]       i_req_be,
    input  logic [LEN_W-1:0] i_req_len,
    input  logic [31:0]      i_wr_data,
    output logic             o_wr_ack,
    output logic [31:0]      o_rd_data,
    output logic             o_rd_valid,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_master_abort,
    inout  wire  [31:0]      io_addr_data,
    output logic [3:0]       o_c_be,
    output logic             o_frame_n,
    output logic             o_irdy_n,
    input  logic             i_trdy_n,
    input  logic             i_devsel_n
);

    localparam int CNT_W = $clog2(DEVSEL_TIMEOUT + 1);

    state_t             r_state;
    logic [31:0]        r_addr;
    logic [3:0]         r_cmd;
    logic [3:0]         r_be;
    logic [LEN_W-1:0]   r_remaining;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_devsel_seen;
    logic               r_abort;
    logic               r_rd_valid;
    logic               r_done;
    logic               r_master_abort;

    state_t             w_next_state;
    logic               w_is_write;
    logic               w_last;
    logic               w_complete;
    logic               w_timeout;
    logic               w_ad_oe;
    logic [31:0]        w_ad_out;
    logic               w_capture;

    // Anything that is not an explicit WRITE moves data target-to-initiator.
    assign w_is_write = (r_cmd == CMD_WRITE);
    assign w_last     = (r_remaining == LEN_W'(1));
    assign w_complete = (r_state == ST_DATA) && !i_trdy_n;
    assign w_timeout  = !r_devsel_seen && i_devsel_n &&
                        (r_cnt >= CNT_W'(DEVSEL_TIMEOUT - 1));
    assign w_capture  = w_complete && !w_is_write;

    assign o_wr_ack       = w_complete && w_is_write;
    assign o_rd_valid     = r_rd_valid;
    assign o_done         = r_done;
    assign o_master_abort = r_master_abort;
    assign o_busy         = (r_state != ST_IDLE);

    always_comb begin
        w_next_state = r_state;
        o_frame_n    = 1'b1;
        o_irdy_n     = 1'b1;
        o_c_be       = 4'hF;
        w_ad_oe      = 1'b0;
        w_ad_out     = r_addr;
        case (r_state)
            ST_IDLE: begin
                if (i_req) begin
                    w_next_state = ST_ADDR;
                end
            end
            ST_ADDR: begin
                o_frame_n    = 1'b0;
                o_c_be       = r_cmd;
                w_ad_oe      = 1'b1;
                w_next_state = w_is_write ? ST_DATA : ST_TURN;
            end
            ST_TURN: begin
                o_irdy_n     = 1'b0;
                o_c_be       = r_be;
                o_frame_n    = w_last;
                w_next_state = w_timeout ? ST_RELEASE : ST_DATA;
            end
            ST_DATA: begin
                o_irdy_n  = 1'b0;
                o_c_be    = r_be;
                o_frame_n = w_last;
                if (w_is_write) begin
                    w_ad_oe  = 1'b1;
                    w_ad_out = i_wr_data;
                end
                // A transfer on the timeout edge takes priority over the abort.
                if (w_complete) begin
                    if (w_last) begin
                        w_next_state = ST_RELEASE;
                    end
                end else if (w_timeout) begin
                    w_next_state = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_addr         <= '0;
            r_cmd          <= '0;
            r_be           <= 4'hF;
            r_remaining    <= '0;
            r_cnt          <= '0;
            r_devsel_seen  <= 1'b0;
            r_abort        <= 1'b0;
            r_rd_valid     <= 1'b0;
            r_done         <= 1'b0;
            r_master_abort <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_rd_valid     <= w_capture;
            r_done         <= (r_state == ST_RELEASE);
            r_master_abort <= (r_state == ST_RELEASE) && r_abort;
            case (r_state)
                ST_IDLE: begin
                    if (i_req) begin
                        r_addr      <= i_req_addr;
                        r_cmd       <= i_req_cmd;
                        r_be        <= i_req_be;
                        r_remaining <= (i_req_len == '0) ? LEN_W'(1) : i_req_len;
                    end
                end
                ST_ADDR: begin
                    r_cnt         <= '0;
                    r_devsel_seen <= 1'b0;
                    r_abort       <= 1'b0;
                end
                ST_TURN, ST_DATA: begin
                    // Once a target claims the cycle the timeout can never fire.
                    if (!i_devsel_n) begin
                        r_devsel_seen <= 1'b1;
                    end else if (!r_devsel_seen && r_cnt < CNT_W'(DEVSEL_TIMEOUT)) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    if (w_complete) begin
                        r_remaining <= r_remaining - LEN_W'(1);
                    end else if (w_timeout) begin
                        r_abort <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    pci_ad_io u_ad_io (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_oe      (w_ad_oe),
        .i_out     (w_ad_out),
        .i_capture (w_capture),
        .o_sample  (o_rd_data),
        .io_ad     (io_addr_data)
    );

endmodule

// File: doc/pci_initiator.md
Name: pci_initiator

Overview:
- PCI bus master that sits directly upstream of the PCI target: drives FRAME, IRDY, C_BE and ADDR_DATA, and consumes TRDY and DEVSEL.
- Converts a simple local request (address, command, burst length) into a PCI address phase followed by N data phases.
- Returns read data and write acknowledges to local logic.
- Detects master abort when no target claims the cycle.

Parameters:
- LEN_W, 4, width of burst-length field; max burst is 2**LEN_W - 1 data phases.
- DEVSEL_TIMEOUT, 5, clocks after the address phase to wait for DEVSEL=0 before master abort.

Ports:
- CLK  input  1  bus clock; all logic on rising edge.
- RST  input  1  synchronous reset, active-high.
- req  input  1  local request strobe; sampled only in IDLE.
- req_addr  input  32  transaction start address.
- req_cmd  input  4  PCI command (READ=4'b0001, WRITE=4'b0010).
- req_be  input  4  active-low byte enables driven on C_BE during data phases.
- req_len  input  LEN_W  number of data phases; 0 is treated as 1.
- wr_data  input  32  write word for the current data phase.
- wr_ack  output  1  one-cycle pulse: current write word transferred; present the next word in the following cycle.
- rd_data  output  32  captured read word.
- rd_valid  output  1  one-cycle pulse with rd_data.
- busy  output  1  high from request acceptance until return to IDLE.
- done  output  1  one-cycle pulse at transaction end (normal or abort).
- master_abort  output  1  one-cycle pulse, coincident with done, when DEVSEL never asserted.
- ADDR_DATA  inout  32  multiplexed AD bus; high-Z when not driving.
- C_BE  output  4  command during the address phase, req_be during data phases.
- FRAME  output  1  active-low.
- IRDY  output  1  active-low.
- TRDY  input  1  active-low, from target.
- DEVSEL  input  1  active-low, from target.

Behaviour:
- Reset values: FRAME=1, IRDY=1, C_BE=4'hF, AD released, busy=0, done=0, wr_ack=0, rd_valid=0, master_abort=0, rd_data=0.
- Reset mid-transaction: all of the above take reset values at the next edge and the state returns to IDLE. No done pulse.
- States: IDLE, ADDR, TURN, DATA, RELEASE.
- IDLE:
  - On req=1, latch addr, cmd, be and len (len of 0 becomes 1) into remaining; busy=1; go to ADDR.
  - req while busy is ignored.
- ADDR (exactly 1 cycle): FRAME=0, IRDY=1, AD=addr, C_BE=cmd. DEVSEL timeout counter is cleared. Next state is TURN for READ, DATA for WRITE.
- TURN (exactly 1 cycle, read only): AD released, C_BE=be, IRDY=0 (FRAME=1 if remaining==1). Go to DATA.
- DATA:
  - IRDY=0 and C_BE=be.
  - FRAME=0 while remaining>1; FRAME=1 while remaining==1, marking the last phase.
  - Write: AD=wr_data. Read: AD released.
  - A phase completes on a rising edge sampling IRDY==0 && TRDY==0.
  - On completion: read captures ADDR_DATA into rd_data with rd_valid=1; write pulses wr_ack=1; remaining decrements.
  - If the completed phase was the last, go to RELEASE.
  - If TRDY=1, the initiator holds IRDY=0 and its outputs stable. Wait states are unbounded once DEVSEL=0.
- Master abort:
  - While DEVSEL=1 after ADDR, the counter increments each clock.
  - When the counter reaches DEVSEL_TIMEOUT, go to RELEASE with master_abort=1. No rd_valid or wr_ack is issued.
  - DEVSEL=0 freezes the counter for the rest of the transaction.
- RELEASE (1 cycle): FRAME=1, IRDY=1, AD released, C_BE=4'hF, done=1, busy=0 at the next edge; go to IDLE. A new req is accepted no earlier than the cycle after RELEASE.
- Simultaneous events:
  - TRDY=0 on the same edge the timeout expires: the transfer wins and the abort is not flagged.
  - Decrement and completion share the edge; remaining never underflows.
- Commands other than READ/WRITE are still driven on the bus, and the data direction is treated as read.

Decomposition:
- Shared package pci_pkg holds:
  - Command constants READ=4'b0001 and WRITE=4'b0010.
  - State encoding typedef for the initiator FSM.
  - Default DEVSEL_TIMEOUT.
  - The target's device_address constant (16'h0000) for benches.
- One natural sub-module: pci_ad_io, the 32-bit tri-state AD driver with output enable and registered sample. The FSM and counters stay in pci_initiator.

Test Plan:
- Single read:
  - Stimulus: req_addr=32'h0000_0010, cmd=READ, len=1; target model asserts DEVSEL in TURN, TRDY=0 in the first data cycle returning 32'hDEADBEEF.
  - Response: FRAME low for exactly 1 clock; rd_valid=1 with rd_data=32'hDEADBEEF; done 1 cycle later; FRAME=IRDY=1 after.
- Burst read with target wait:
  - Stimulus: len=3; target holds TRDY=1 for 2 clocks on phase 2.
  - Response: exactly 3 rd_valid pulses; IRDY stays 0 through the wait; FRAME rises in the cycle phase 3 is presented.
- Burst write:
  - Stimulus: len=2, wr_data=32'h1111_1111 then 32'h2222_2222; target TRDY=0 immediately.
  - Response: AD shows both words in order; 2 wr_ack pulses; no TURN state.
- Master abort:
  - Stimulus: req_addr=32'h0001_0000; target keeps DEVSEL=1.
  - Response: after DEVSEL_TIMEOUT=5 clocks, master_abort=1 and done=1; no rd_valid; bus released.
- Reset mid-burst:
  - Stimulus: assert RST during phase 2 of a len=4 read.
  - Response: next edge gives FRAME=1, IRDY=1, AD high-Z, busy=0, no done pulse. A following req works normally.
- Back-to-back:
  - Stimulus: req held high throughout.
  - Response: second ADDR phase starts no earlier than 1 cycle after RELEASE; req asserted while busy is ignored.
